// File: rtl/paillier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : paillier_pkg
// Description : Shared widths, FSM state encoding and timing constants for
//               the Paillier encryption/decryption datapaths.
//               Key format: two 32-bit primes p, q; modulus n = p*q (64 b),
//               n^2 (128 b).
// Revision    : 1.0 - initial release
// ============================================================================
package paillier_pkg;

    localparam int W_KEY         = 32;
    localparam int W_N           = 64;
    localparam int W_N2          = 128;
    localparam int MODMUL_CYCLES = 128;

    localparam int W_STATE = 3;
    typedef logic [W_STATE-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_PREP  = 3'd2;
    localparam state_t ST_SQR   = 3'd3;
    localparam state_t ST_MUL   = 3'd4;
    localparam state_t ST_FINAL = 3'd5;
    localparam state_t ST_DONE  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/paillier_modmul.sv
`default_nettype none
// ============================================================================
// Module      : paillier_modmul
// Description : Interleaved MSB-first shift-add modular multiplier,
//               result = a*b mod m. One issue cycle latches the operands,
//               then 128 iterations each do acc = 2*acc mod m followed by
//               acc = acc + a mod m when the current bit of b is set.
//               Operands must already be reduced (< m).
// Ports       : clk, rst (async, active-low), start (issue, ignored while
//               running), a/b/m (128 b operands), result (128 b),
//               done (high during the final iteration cycle; result is
//               valid in that same cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module paillier_modmul
    import paillier_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W_N2-1:0] a,
    input  logic [W_N2-1:0] b,
    input  logic [W_N2-1:0] m,
    output logic [W_N2-1:0] result,
    output logic            done
);

    localparam int W_CNT = $clog2(MODMUL_CYCLES);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(MODMUL_CYCLES - 1);

    logic [W_N2-1:0]  a_hold;
    logic [W_N2-1:0]  b_shift;
    logic [W_N2-1:0]  m_hold;
    logic [W_N2-1:0]  acc;
    logic [W_CNT-1:0] cnt;
    logic             running;

    // 129-bit intermediates: doubling or adding a reduced value to a
    // reduced value can carry past bit 127 before the conditional subtract.
    logic [W_N2:0]    dbl;
    logic [W_N2:0]    dbl_red;
    logic [W_N2:0]    sum;
    logic [W_N2-1:0]  sum_red;

    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= {1'b0, m_hold}) ? dbl - {1'b0, m_hold} : dbl;
        sum     = dbl_red + (b_shift[W_N2-1] ? {1'b0, a_hold} : '0);
        sum_red = W_N2'((sum >= {1'b0, m_hold}) ? sum - {1'b0, m_hold} : sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_hold  <= '0;
            b_shift <= '0;
            m_hold  <= '0;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start && !running) begin
            a_hold  <= a;
            b_shift <= b;
            m_hold  <= m;
            acc     <= '0;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= sum_red;
            b_shift <= b_shift << 1;
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                running <= 1'b0;
            end
        end
    end

    // Result is presented combinationally on the last iteration so the
    // caller can capture it and issue the next product without a gap cycle.
    assign done   = running && (cnt == CNT_LAST);
    assign result = sum_red;

endmodule
`default_nettype wire

// File: rtl/encryption.sv
`default_nettype none
// ============================================================================
// Module      : encryption
// Description : Paillier encryption, c = (1 + m*n) * r^n mod n^2, g = n+1.
//               r^n is computed by MSB-first square-and-multiply over all
//               64 bits of n, then multiplied by gm = 1 + m*n.
// Ports       : clk, rst (async, active-low), start (sampled in IDLE),
//               plain_text/p/q/r (32 b), cipher_text (128 b, held until
//               next accepted start), done (1-cycle pulse), err (invalid
//               inputs, held), busy (cycle after accept through DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module encryption
    import paillier_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_KEY-1:0] plain_text,
    input  logic [W_KEY-1:0] p,
    input  logic [W_KEY-1:0] q,
    input  logic [W_KEY-1:0] r,
    output logic [W_N2-1:0]  cipher_text,
    output logic             done,
    output logic             err,
    output logic             busy
);

    state_t                 state;
    state_t                 state_next;

    logic [W_KEY-1:0]       lat_m;
    logic [W_KEY-1:0]       lat_p;
    logic [W_KEY-1:0]       lat_q;
    logic [W_KEY-1:0]       lat_r;
    logic [W_N-1:0]         n;
    logic [W_N2-1:0]        n2;
    logic [W_N2-1:0]        gm;
    logic [W_N2-1:0]        acc;
    logic [$clog2(W_N)-1:0] bit_idx;
    logic                   issued;
    logic                   invalid;
    logic                   last_bit;

    logic                   mm_start;
    logic [W_N2-1:0]        mm_a;
    logic [W_N2-1:0]        mm_b;
    logic [W_N2-1:0]        mm_result;
    logic                   mm_done;

    assign invalid  = (lat_p < W_KEY'(2)) || (lat_q < W_KEY'(2)) ||
                      (W_N'(lat_m) >= n) || (lat_r == '0) || (W_N'(lat_r) >= n);
    assign last_bit = (bit_idx == '0);

    paillier_modmul u_modmul (
        .clk    (clk),
        .rst    (rst),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .m      (n2),
        .result (mm_result),
        .done   (mm_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_PREP;
            ST_PREP:  state_next = invalid ? ST_DONE : ST_SQR;
            ST_SQR: begin
                if (mm_done) begin
                    if (n[bit_idx])    state_next = ST_MUL;
                    else if (last_bit) state_next = ST_FINAL;
                    else               state_next = ST_SQR;
                end
            end
            ST_MUL:   if (mm_done) state_next = last_bit ? ST_FINAL : ST_SQR;
            ST_FINAL: if (mm_done) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs and multiplier operand selection
    always_comb begin
        done     = (state == ST_DONE);
        busy     = (state != ST_IDLE);
        mm_start = 1'b0;
        mm_a     = acc;
        mm_b     = acc;
        case (state)
            ST_SQR:   mm_start = !issued;
            ST_MUL: begin
                mm_start = !issued;
                mm_b     = W_N2'(lat_r);
            end
            ST_FINAL: begin
                mm_start = !issued;
                mm_b     = gm;
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_m       <= '0;
            lat_p       <= '0;
            lat_q       <= '0;
            lat_r       <= '0;
            n           <= '0;
            n2          <= '0;
            gm          <= '0;
            acc         <= '0;
            bit_idx     <= '0;
            issued      <= 1'b0;
            cipher_text <= '0;
            err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_m       <= plain_text;
                        lat_p       <= p;
                        lat_q       <= q;
                        lat_r       <= r;
                        cipher_text <= '0;
                        err         <= 1'b0;
                    end
                end
                ST_SETUP: n <= W_N'(lat_p) * W_N'(lat_q);
                ST_PREP: begin
                    n2      <= W_N2'(n) * W_N2'(n);
                    gm      <= W_N2'(1) + W_N2'(lat_m) * W_N2'(n);
                    acc     <= W_N2'(1);
                    bit_idx <= '1;
                    issued  <= 1'b0;
                    if (invalid) begin
                        err         <= 1'b1;
                        cipher_text <= '0;
                    end
                end
                ST_SQR, ST_MUL, ST_FINAL: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (mm_done) begin
                        acc    <= mm_result;
                        issued <= 1'b0;
                        // A bit is finished after its MUL, or after its SQR
                        // when the bit is clear.
                        if (state == ST_MUL || (state == ST_SQR && !n[bit_idx])) begin
                            bit_idx <= bit_idx - 1'b1;
                        end
                        if (state == ST_FINAL) begin
                            cipher_text <= mm_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encryption.sv
`default_nettype none
// ============================================================================
// Module      : tb_encryption
// Description : Self-checking bench for encryption. Directed known-answer
//               runs, invalid inputs, restart-while-busy, reset mid-run and
//               randomized small-prime runs against an arithmetic model.
//               Latency is counted through the clock edge on which done is
//               first captured.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encryption;

    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  plain_text = '0;
    logic [31:0]  p = '0;
    logic [31:0]  q = '0;
    logic [31:0]  r = '0;
    logic [127:0] cipher_text;
    logic         done;
    logic         err;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    encryption dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .plain_text  (plain_text),
        .p           (p),
        .q           (q),
        .r           (r),
        .cipher_text (cipher_text),
        .done        (done),
        .err         (err),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // base^e mod md, LSB-first, with 256-bit intermediates
    function automatic logic [127:0] modpow(input logic [127:0] base, input logic [63:0] e,
                                            input logic [127:0] md);
        logic [255:0] res;
        logic [255:0] bb;
        res = 256'd1 % {128'd0, md};
        bb  = {128'd0, base} % {128'd0, md};
        for (int i = 0; i < 64; i++) begin
            if (e[i]) res = (res * bb) % {128'd0, md};
            bb = (bb * bb) % {128'd0, md};
        end
        return res[127:0];
    endfunction

    task automatic model_enc(input logic [31:0] pp, qq, mm, rr,
                             output logic [127:0] c, output logic e, output int lat);
        logic [63:0]  n;
        logic [127:0] n2;
        logic [255:0] prod;
        n  = {32'd0, pp} * {32'd0, qq};
        n2 = {64'd0, n} * {64'd0, n};
        e  = (pp < 2) || (qq < 2) || ({32'd0, mm} >= n) || (rr == 0) || ({32'd0, rr} >= n);
        if (e) begin
            c   = '0;
            lat = 3;
        end else begin
            prod = {128'd0, 128'd1 + {96'd0, mm} * {64'd0, n}} *
                   {128'd0, modpow({96'd0, rr}, n, n2)};
            c    = 128'(prod % {128'd0, n2});
            lat  = 3 + 129 * (65 + $countones(n));
        end
    endtask

    // Called at posedge+1 with the DUT idle; leaves at posedge+1 one cycle
    // after the done cycle.
    task automatic run_and_check(input string tag, input logic [31:0] pp, qq, mm, rr,
                                 output logic [127:0] c);
        logic [127:0] exp_c;
        logic         exp_e;
        int           exp_lat;
        int           lat;
        model_enc(pp, qq, mm, rr, exp_c, exp_e, exp_lat);
        plain_text = mm; p = pp; q = qq; r = rr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, {127'd0, busy}, 128'd1);
        lat = 1;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_done_seen"}, {127'd0, done}, 128'd1);
        check({tag, "_cipher"}, cipher_text, exp_c);
        check({tag, "_err"}, {127'd0, err}, {127'd0, exp_e});
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        c = cipher_text;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
        check({tag, "_idle"}, {127'd0, busy}, 128'd0);
        check({tag, "_hold"}, {cipher_text[126:0], err}, {exp_c[126:0], exp_e});
    endtask

    initial begin
        logic [127:0] c;
        logic [127:0] u;
        logic [127:0] dec;
        int           ndone;
        int           lat;
        int           primes[] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43,
                                   47, 53, 59, 61, 67, 71, 73, 79, 83, 89, 97, 101,
                                   103, 107, 109, 113, 127, 131, 137, 139, 149, 151};

        // Reset state
        #12;
        check("rst_cipher", cipher_text, 128'd0);
        check("rst_flags", {125'd0, done, err, busy}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Known answers
        run_and_check("ka_m42_r1", 32'd13, 32'd7, 32'd42, 32'd1, c);
        check("ka_m42_r1_const", c, 128'd3823);
        run_and_check("ka_m0_r90", 32'd13, 32'd7, 32'd0, 32'd90, c);
        check("ka_m0_r90_const", c, 128'd8280);
        run_and_check("ka_m5_r90", 32'd13, 32'd7, 32'd5, 32'd90, c);
        check("ka_m5_r90_const", c, 128'd7825);

        // Invalid inputs
        run_and_check("inv_m91", 32'd13, 32'd7, 32'd91, 32'd5, c);
        run_and_check("inv_r0", 32'd13, 32'd7, 32'd5, 32'd0, c);
        run_and_check("inv_p1", 32'd1, 32'd7, 32'd3, 32'd2, c);

        // Round trip through lambda=12, mu=38 decryption
        run_and_check("rt", 32'd13, 32'd7, 32'd42, 32'd23, c);
        u   = modpow(c, 64'd12, 128'd8281);
        dec = (((u - 128'd1) / 128'd91) * 128'd38) % 128'd91;
        check("rt_decrypt", dec, 128'd42);

        // Restart attempts while busy are ignored
        plain_text = 32'd42; p = 32'd13; q = 32'd7; r = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        lat   = 1;
        for (int i = 0; i < 300; i++) begin
            start      = (i == 50 || i == 200);
            plain_text = 32'd5; r = 32'd90; p = 32'd11; q = 32'd13;
            @(posedge clk); #1;
            lat++;
            if (done) ndone++;
        end
        start = 1'b0;
        while (!done && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        check("restart_done_seen", {127'd0, done}, 128'd1);
        check("restart_cipher", cipher_text, 128'd3823);
        check("restart_latency", 128'(lat), 128'(9033));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("restart_no_extra_done", 128'(ndone), 128'd0);

        // Reset in the middle of SQR
        plain_text = 32'd42; p = 32'd13; q = 32'd7; r = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (500) @(posedge clk);
        #4;
        rst = 1'b0;
        #1;
        check("midrst_flags", {125'd0, done, err, busy}, 128'd0);
        check("midrst_cipher", cipher_text, 128'd0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        rst = 1'b1;
        for (int i = 0; i < 1; i++) begin
            if (done) ndone++;
        end
        check("midrst_quiet", 128'(ndone), 128'd0);
        run_and_check("after_rst", 32'd13, 32'd7, 32'd42, 32'd1, c);

        // Randomized small-prime runs
        for (int t = 0; t < 2; t++) begin
            logic [31:0] rp, rq, rn, rm, rr;
            rp = 32'(primes[$urandom_range(0, primes.size() - 1)]);
            rq = 32'(primes[$urandom_range(0, primes.size() - 1)]);
            rn = rp * rq;
            rm = $urandom_range(0, rn - 1);
            rr = $urandom_range(1, rn - 1);
            run_and_check($sformatf("rand%0d", t), rp, rq, rm, rr, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
